// File: rtl/disp_pkg.sv
// Shared types and helpers for the segment display scheduler: requester count,
// display word width, FSM encoding and small index/word-select functions.
package disp_pkg;

  localparam int NUM_REQ = 3;
  localparam int WORD_W  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  // Advance a requester index modulo 3; index 3 is never produced and folds to 0.
  function automatic logic [1:0] next3(input logic [1:0] p);
    return (p >= 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot3(input logic [1:0] i);
    case (i)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [WORD_W-1:0] word_sel(input logic [NUM_REQ*WORD_W-1:0] w,
                                                 input logic [1:0] i);
    case (i)
      2'd0:    return w[WORD_W-1:0];
      2'd1:    return w[2*WORD_W-1:WORD_W];
      default: return w[3*WORD_W-1:2*WORD_W];
    endcase
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin search over three requesters: returns the first
// request (not masked by excl) found starting at start and wrapping modulo 3.
module rr_pick3
  import disp_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         start,
  input  logic [NUM_REQ-1:0] excl,
  output logic               found,
  output logic [1:0]         idx
);

  logic [NUM_REQ-1:0] cand;
  logic [1:0]         p0;
  logic [1:0]         p1;
  logic [1:0]         p2;

  assign cand = req & ~excl;
  assign p0   = (start == 2'd3) ? 2'd0 : start;
  assign p1   = next3(p0);
  assign p2   = next3(p1);

  always_comb begin
    found = 1'b0;
    idx   = 2'd0;
    if (cand[p0]) begin
      found = 1'b1;
      idx   = p0;
    end else if (cand[p1]) begin
      found = 1'b1;
      idx   = p1;
    end else if (cand[p2]) begin
      found = 1'b1;
      idx   = p2;
    end
  end

endmodule

// File: rtl/seg_disp_sched.sv
// Time-sliced owner scheduler for a 4-digit hex display: one requester owns the
// display for DWELL ticks, then ownership rotates round-robin among requesters.
module seg_disp_sched
  import disp_pkg::*;
#(
  parameter logic [15:0] DWELL      = 16'd2000,
  parameter logic [15:0] IDLE_VALUE = 16'h0000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tick,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*WORD_W-1:0] req_value,
  output logic [WORD_W-1:0]         value,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output state_t                    fsm_state
);

  // A dwell of zero is treated as one tick.
  localparam logic [15:0] DWELL_LAST = (DWELL == 16'd0) ? 16'd0 : DWELL - 16'd1;

  state_t              state, state_nxt;
  logic [1:0]          owner, owner_nxt;
  logic [1:0]          rr, rr_nxt;
  logic [15:0]         cnt, cnt_nxt;
  logic [WORD_W-1:0]   value_nxt;
  logic [NUM_REQ-1:0]  grant_nxt;
  logic                busy_nxt;
  logic [NUM_REQ-1:0]  pick_excl;
  logic                pick_found;
  logic [1:0]          pick_idx;
  logic                do_grant;
  logic                go_idle;

  rr_pick3 u_pick (
    .req   (req),
    .start (rr),
    .excl  (pick_excl),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= 2'd0;
      rr    <= 2'd0;
      cnt   <= 16'd0;
      value <= IDLE_VALUE;
      grant <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      rr    <= rr_nxt;
      cnt   <= cnt_nxt;
      value <= value_nxt;
      grant <= grant_nxt;
      busy  <= busy_nxt;
    end
  end

  assign fsm_state = state;

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    rr_nxt    = rr;
    cnt_nxt   = cnt;
    value_nxt = value;
    grant_nxt = grant;
    busy_nxt  = busy;
    pick_excl = '0;
    do_grant  = 1'b0;
    go_idle   = 1'b0;

    case (state)
      IDLE: begin
        if (pick_found) do_grant = 1'b1;
      end
      SHOW: begin
        pick_excl = onehot3(owner);
        value_nxt = word_sel(req_value, owner);
        // Release wins over a coincident expiry.
        if (!req[owner]) begin
          if (pick_found) do_grant = 1'b1;
          else            go_idle  = 1'b1;
        end else if (tick && (cnt == DWELL_LAST)) begin
          if (pick_found) do_grant = 1'b1;
          else            cnt_nxt  = 16'd0;
        end else if (tick) begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      default: go_idle = 1'b1;
    endcase

    if (do_grant) begin
      state_nxt = SHOW;
      owner_nxt = pick_idx;
      grant_nxt = onehot3(pick_idx);
      busy_nxt  = 1'b1;
      value_nxt = word_sel(req_value, pick_idx);
      rr_nxt    = next3(pick_idx);
      cnt_nxt   = 16'd0;
    end
    if (go_idle) begin
      state_nxt = IDLE;
      grant_nxt = '0;
      busy_nxt  = 1'b0;
      value_nxt = IDLE_VALUE;
      cnt_nxt   = 16'd0;
    end
  end

endmodule
